// File: rtl/count_60_down_pkg.sv
// rtl/count_60_down_pkg.sv - shared BCD types, constants and validity check for the mod-60 down counter
//
// Purpose : common definitions imported by the counter top, its digit sub-module and its interface.
// Contents: bcd_digit_t (one BCD digit), bcd_byte_t ({tens, units}), digit limits,
//           the wrap value 59 and bcd_valid() which accepts 00..59 only.
package count_60_down_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd_byte_t;

    localparam int        DIGIT_MAX_UNITS = 9;
    localparam int        DIGIT_MAX_TENS  = 5;
    localparam bcd_byte_t WRAP_VAL        = 8'h59;

    // True when both digits are inside the mod-60 BCD range.
    function automatic logic bcd_valid(input bcd_byte_t value);
        return (value[3:0] <= 4'(DIGIT_MAX_UNITS)) && (value[7:4] <= 4'(DIGIT_MAX_TENS));
    endfunction

endpackage

// File: rtl/count_60_down_if.sv
// rtl/count_60_down_if.sv - control/status bundle of the mod-60 down counter
//
// Purpose : groups the counter's control inputs and status outputs.
// Signals : en, load, din[7:0]          - driven by the master (controller)
//           count[7:0], bo, zero, load_err - driven by the slave (counter)
// Modports: master (controller side), slave (counter side).
interface count_60_down_if;
    import count_60_down_pkg::*;

    logic      en;
    logic      load;
    bcd_byte_t din;
    bcd_byte_t count;
    logic      bo;
    logic      zero;
    logic      load_err;

    modport master (
        output en, load, din,
        input  count, bo, zero, load_err
    );

    modport slave (
        input  en, load, din,
        output count, bo, zero, load_err
    );

endinterface

// File: rtl/count_60_down_bcd_down_digit.sv
// rtl/count_60_down_bcd_down_digit.sv - one BCD digit counting down from MAX to 0 and wrapping to MAX
//
// Purpose : single decade/sexta-decade digit of the countdown chain.
// Ports   : clk, rst (async, active high), en (decrement), load (parallel load, wins over en),
//           din[3:0] (load value), q[3:0] (digit value), bo (combinational borrow: en & ~load & q==0).
module bcd_down_digit
    import count_60_down_pkg::*;
#(
    parameter int         MAX = 9,
    parameter bcd_digit_t RST = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  bcd_digit_t din,
    output bcd_digit_t q,
    output logic       bo
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST;
        end else if (load) begin
            q <= din;
        end else if (en) begin
            // An out-of-range digit is treated like zero so it recovers to MAX.
            if ((q == 4'd0) || (q > 4'(MAX))) begin
                q <= 4'(MAX);
            end else begin
                q <= q - 4'd1;
            end
        end
    end

    assign bo = en & ~load & (q == 4'd0);

endmodule

// File: rtl/count_60_down.sv
// rtl/count_60_down.sv - mod-60 BCD down counter (59..00, wraps to 59) with validated parallel load
//
// Purpose : countdown timer stage; bo feeds en of the next more-significant stage.
// Ports   : clk      - rising-edge clock
//           rst      - asynchronous active-high reset (count=RST_VAL)
//           bus      - slave modport: en, load, din[7:0] in; count[7:0], bo, zero, load_err out
// Params  : RST_VAL  - BCD reset value, 00..59
module count_60_down
    import count_60_down_pkg::*;
#(
    parameter bcd_byte_t RST_VAL = 8'h00
) (
    input  logic            clk,
    input  logic            rst,
    count_60_down_if.slave  bus
);

    bcd_digit_t units;
    bcd_digit_t tens;
    logic       units_bo;
    logic       tens_bo;
    logic       din_ok;
    logic       load_ok;
    logic       step;
    logic       force_wrap;
    logic       dig_load;
    bcd_byte_t  dig_din;
    logic       zero_next;

    assign din_ok  = bcd_valid(bus.din);
    assign load_ok = bus.load & din_ok;
    assign step    = bus.en & ~bus.load;

    // A corrupted count can never be produced by this logic, but if one appears
    // the next decrement reloads both digits with 59 so the pair stays coherent.
    assign force_wrap = step & ~bcd_valid({tens, units});
    assign dig_load   = load_ok | force_wrap;
    assign dig_din    = load_ok ? bus.din : WRAP_VAL;

    bcd_down_digit #(
        .MAX (DIGIT_MAX_UNITS),
        .RST (RST_VAL[3:0])
    ) u_units (
        .clk  (clk),
        .rst  (rst),
        .en   (step),
        .load (dig_load),
        .din  (dig_din[3:0]),
        .q    (units),
        .bo   (units_bo)
    );

    bcd_down_digit #(
        .MAX (DIGIT_MAX_TENS),
        .RST (RST_VAL[7:4])
    ) u_tens (
        .clk  (clk),
        .rst  (rst),
        .en   (units_bo),
        .load (dig_load),
        .din  (dig_din[7:4]),
        .q    (tens),
        .bo   (tens_bo)
    );

    // Next count is zero for a valid load of 00, a decrement from 01, or holding at 00
    // (an invalid load also holds).
    always_comb begin
        zero_next = 1'b0;
        if (load_ok) begin
            zero_next = (bus.din == 8'h00);
        end else if (step) begin
            zero_next = ({tens, units} == 8'h01);
        end else begin
            zero_next = ({tens, units} == 8'h00);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.zero     <= (RST_VAL == 8'h00);
            bus.load_err <= 1'b0;
        end else begin
            bus.zero     <= zero_next;
            bus.load_err <= bus.load & ~din_ok;
        end
    end

    assign bus.count = {tens, units};
    // tens_bo is only high when both digits borrow, i.e. count==00 with en & ~load.
    assign bus.bo    = tens_bo & ~rst;

endmodule

// File: tb/tb_count_60_down.sv
// tb/tb_count_60_down.sv - self-checking bench for count_60_down with a two-stage cascade
module tb_count_60_down;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    count_60_down_if if_a ();
    count_60_down_if if_b ();

    assign if_b.en = if_a.bo;

    count_60_down #(.RST_VAL(8'h00)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    count_60_down #(.RST_VAL(8'h00)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    int   n_cmp = 0;
    int   n_bad = 0;
    int   mv_a  = 0;
    int   mv_b  = 0;
    bit   merr_a = 1'b0;
    bit   merr_b = 1'b0;
    bit   m_bo_a;
    bit   chk_on = 1'b0;
    logic last_bo;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic bit din_ok(input logic [7:0] d);
        return (int'(d[3:0]) <= 9) && (int'(d[7:4]) <= 5);
    endfunction

    function automatic int from_bcd(input logic [7:0] d);
        return int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counter value as a plain integer 0..59.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mv_a = 0; mv_b = 0; merr_a = 1'b0; merr_b = 1'b0;
        end else begin
            m_bo_a = if_a.en && !if_a.load && (mv_a == 0);
            if (if_b.load) begin
                if (din_ok(if_b.din)) begin mv_b = from_bcd(if_b.din); merr_b = 1'b0; end
                else merr_b = 1'b1;
            end else begin
                merr_b = 1'b0;
                if (m_bo_a) mv_b = (mv_b == 0) ? 59 : mv_b - 1;
            end
            if (if_a.load) begin
                if (din_ok(if_a.din)) begin mv_a = from_bcd(if_a.din); merr_a = 1'b0; end
                else merr_a = 1'b1;
            end else begin
                merr_a = 1'b0;
                if (if_a.en) mv_a = (mv_a == 0) ? 59 : mv_a - 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_count", if_a.count, to_bcd(mv_a));
            chk("a_zero", 8'(if_a.zero), 8'(mv_a == 0));
            chk("a_load_err", 8'(if_a.load_err), 8'(merr_a));
            chk("a_bo", 8'(if_a.bo), 8'(if_a.en && !if_a.load && !rst && mv_a == 0));
            chk("b_count", if_b.count, to_bcd(mv_b));
            chk("b_zero", 8'(if_b.zero), 8'(mv_b == 0));
            chk("b_load_err", 8'(if_b.load_err), 8'(merr_b));
            chk("b_bo", 8'(if_b.bo),
                8'(if_a.en && !if_a.load && !rst && mv_a == 0 && !if_b.load && mv_b == 0));
        end
    end

    task automatic step(input logic e, input logic l, input logic [7:0] d,
                        input logic lb, input logic [7:0] db);
        if_a.en = e; if_a.load = l; if_a.din = d;
        if_b.load = lb; if_b.din = db;
        @(negedge clk);
        last_bo = if_a.bo;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_bo;
        rst = 1'b1;
        if_a.en = 1'b0; if_a.load = 1'b0; if_a.din = 8'h00;
        if_b.load = 1'b0; if_b.din = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_count", if_a.count, 8'h00);
        chk("reset_zero", 8'(if_a.zero), 8'h01);
        chk_on = 1'b1;

        // Digit borrow: 40 -> 39
        step(1'b0, 1'b1, 8'h40, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("borrow_bo", 8'(last_bo), 8'h00);
        chk("borrow_count", if_a.count, 8'h39);

        // Wrap 00 -> 59 with bo in the same cycle
        step(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("wrap_bo", 8'(last_bo), 8'h01);
        chk("wrap_count", if_a.count, 8'h59);
        chk("wrap_zero", 8'(if_a.zero), 8'h00);

        // 60 decrements from 59: one bo pulse, back to 59
        n_bo = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
            n_bo += int'(last_bo);
        end
        chk("run60_bo_pulses", 8'(n_bo), 8'd1);
        chk("run60_count", if_a.count, 8'h59);

        // Load wins over en at 00
        step(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h25, 1'b0, 8'h00);
        chk("prio_bo", 8'(last_bo), 8'h00);
        chk("prio_count", if_a.count, 8'h25);

        // Invalid load is rejected with a one-cycle error pulse
        step(1'b0, 1'b1, 8'h12, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h6A, 1'b0, 8'h00);
        chk("bad_load_count", if_a.count, 8'h12);
        chk("bad_load_err", 8'(if_a.load_err), 8'h01);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("bad_load_err_clear", 8'(if_a.load_err), 8'h00);
        chk("bad_load_hold", if_a.count, 8'h12);
        step(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00);
        chk("bad_units_err", 8'(if_a.load_err), 8'h01);

        // Cascade: both at 01, two decrements -> {59, 00}
        step(1'b0, 1'b1, 8'h01, 1'b1, 8'h01);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("cascade_a", if_a.count, 8'h59);
        chk("cascade_b", if_b.count, 8'h00);
        chk("cascade_b_zero", 8'(if_b.zero), 8'h01);

        // Asynchronous reset mid-count at 37
        step(1'b0, 1'b1, 8'h38, 1'b0, 8'h00);
        if_a.en = 1'b1; if_a.load = 1'b0;
        @(posedge clk);
        #3;
        chk("pre_reset_count", if_a.count, 8'h37);
        rst = 1'b1;
        #1;
        chk("async_reset_count", if_a.count, 8'h00);
        chk("async_reset_zero", 8'(if_a.zero), 8'h01);
        chk("async_reset_bo", 8'(if_a.bo), 8'h00);
        chk("async_reset_err", 8'(if_a.load_err), 8'h00);
        @(posedge clk);
        #1;
        if_a.en = 1'b0;
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("post_reset_hold", if_a.count, 8'h00);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_60_down.md
Name: count_60_down

Overview:
- Mod-60 BCD down counter: 59 → 58 → … → 00 → 59.
- Counts the opposite direction of the team's mod-60 up counter and is the countdown/borrow-chain counterpart of it.
- Used for countdown timers (seconds/minutes). Its `bo` (borrow out) feeds the `en` of the next, more-significant counter stage.
- Adds parallel BCD load with validity checking.

Parameters:
- RST_VAL, 8'h00, BCD value loaded on reset; must be valid BCD within 00..59.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- en  input  1  count enable; one decrement per clk cycle while high
- load  input  1  synchronous parallel load request
- din  input  8  load value, BCD: {tens[7:4], units[3:0]}
- count  output  8  current value, BCD: {tens[7:4], units[3:0]}
- bo  output  1  borrow out, combinational; high in the cycle where the counter wraps 00 → 59
- zero  output  1  registered; high while count == 8'h00
- load_err  output  1  registered one-cycle pulse; set when a load with invalid BCD is rejected

Behaviour:
- Reset (async, rst=1):
  - count=RST_VAL; zero=(RST_VAL==0); load_err=0.
  - bo=0 while rst is high.
  - Reset takes effect immediately, mid-count included; no partial decrement survives it.
- Priority per rising clk edge: load > en > hold.
- Load path:
  - din is valid if units ≤ 9 and tens ≤ 5.
  - Valid: count←din and load_err←0.
  - Invalid: count holds and load_err←1 for exactly one cycle.
  - en is ignored in any cycle where load=1.
- Decrement path (en=1, load=0):
  - units≠0: units←units−1, tens unchanged.
  - units==0, tens≠0: units←9, tens←tens−1.
  - units==0, tens==0: count←8'h59.
- Hold: en=0 and load=0 → count, zero unchanged; load_err←0.
- bo = en & ~load & ~rst & (count==8'h00), combinational.
  - Any cascade rule: the next stage's en is this stage's bo.
  - Matches the `co` convention of the up counter, so stages chain the same way in either direction.
- Units-digit borrow (internal) = en & ~load & (units==0). It enables the tens digit.
- zero is updated from the next-state value, so it is coincident with count.
- Latency: count, zero and load_err change on the edge after the request; bo has zero latency.
- Illegal internal state cannot occur: loads are validated and reset is valid. Defensive rule: if units>9 or tens>5 is ever present, the next en forces 8'h59.
- Multi-cycle en: one decrement per cycle, no skipping. en held for 60 cycles returns count to its start value with exactly one bo pulse.

Decomposition:
- Shared package:
  - BCD digit type (4-bit).
  - Constants DIGIT_MAX_UNITS=9, DIGIT_MAX_TENS=5, WRAP_VAL=8'h59.
  - BCD validity check function.
- Natural sub-module: bcd_down_digit.
  - Parameter MAX.
  - Ports: clk, rst, en, load, din[3:0], q[3:0], bo.
  - Instantiated twice: units with MAX=9, tens with MAX=5.
- Validity check and load_err register live in the top level.

Test Plan:
- Reset: rst=1 mid-count at count=8'h37 → count=8'h00 immediately (no clk needed), zero=1, bo=0, load_err=0.
- Digit borrow: load 8'h40, then en=1 for one cycle → count=8'h39; bo stays 0.
- Wrap: count=8'h00, en=1 → bo=1 in the same cycle, then count=8'h59 and zero=0 after the edge. Holding en for 60 cycles gives exactly one bo pulse and returns to 8'h59.
- Load priority: count=8'h00, en=1, load=1, din=8'h25 → bo=0 that cycle, count=8'h25 next.
- Invalid load: din=8'h6A, load=1 at count=8'h12 → count stays 8'h12; load_err=1 for one cycle, then 0.
- Cascade: two instances, second stage's en = first stage's bo; both preset to 8'h01, en=1 → after 2 cycles {8'h59, 8'h00} (first stage wrapped, second decremented once).
